mips_bus_arbiter: RTL and testbench
===================================

// Module: mips_bus_arbiter
// PURPOSE
// - Shares the CPU's single Avalon memory-mapped master port between two requesters:
//   the instruction-fetch port (I) and the load/store data port (D).
// - Sits between the CPU core and the external bus; each requester gets an
//   Avalon-style slave interface with its own waitrequest. One transfer in flight at a time.
// PARAMETERS
// - ROUND_ROBIN     0  0: D always wins a tie; 1: tie goes to the port not granted last
// - TIMEOUT_CYCLES  0  stalled cycles before bus_timeout sets; 0 disables the check
// PORTS
// - clk             in   1   single clock; all state updates on rising edge
// - reset_n         in   1   asynchronous, active-low reset
// - if_read         in   1   fetch request (read only)
// - if_address      in   32  fetch address
// - if_waitrequest  out  1   high until fetch completes
// - if_readdata     out  32  fetch data, valid when if_read && !if_waitrequest
// - d_read          in   1   data read request
// - d_write         in   1   data write request
// - d_address       in   32  data address
// - d_writedata     in   32  data write value
// - d_byteenable    in   4   data byte lanes
// - d_waitrequest   out  1   high until data transfer completes
// - d_readdata      out  32  load data, valid when d_read && !d_waitrequest
// - address/read/write/writedata/byteenable  out  32/1/1/32/4  Avalon master outputs
// - waitrequest     in   1   Avalon slave stall
// - readdata        in   32  Avalon read data, valid in the cycle waitrequest is low
// - busy            out  1   state != IDLE
// - bus_timeout     out  1   sticky stall-timeout flag
// BEHAVIOUR
// - Reset (async, immediate): state=IDLE, last_grant=I, stall_cnt=0, bus_timeout=0;
//   address/writedata=0, read/write=0, byteenable=0; if_/d_waitrequest=1, *_readdata=0.
// - States IDLE, BUS_I, BUS_D; state, last_grant, stall_cnt are registers.
// - IDLE: samples requests. D pending and (!if_read or D wins tie) -> BUS_D;
//   else if_read -> BUS_I; else stay. D wins tie: ROUND_ROBIN=0 always,
//   ROUND_ROBIN=1 iff last_grant==I. last_grant updates on entry to BUS_x.
// - Master outputs driven combinationally from granted port while in BUS_x; 0 in IDLE.
//   BUS_I: address=if_address, read=1, write=0, byteenable=4'b1111, writedata=0.
//   BUS_D: D fields passed through; d_read && d_write both high -> write wins, read=0.
// - Latency: request seen in IDLE cycle N -> bus asserted cycle N+1; with waitrequest=0
//   the transfer completes in N+1. Minimum 2 cycles per transfer (one IDLE turnaround).
// - x_waitrequest = !(state==BUS_x && !waitrequest); always 1 for the ungranted port.
// - x_readdata = readdata when state==BUS_x, else 0 (combinational pass-through).
// - BUS_x: waitrequest=1 -> hold, stall_cnt+1 (saturating); waitrequest=0 -> complete,
//   -> IDLE, stall_cnt=0.
// - Requesters hold request signals stable while their waitrequest is high; requests
//   dropped before grant are ignored (no transfer issued).
// - Timeout: TIMEOUT_CYCLES>0 and stall_cnt reaches TIMEOUT_CYCLES -> bus_timeout=1,
//   sticky until reset; the transfer is NOT abandoned and keeps waiting.
// - Reset mid-transfer: outputs drop at once, transfer abandoned; requests still high
//   after reset_n rises are re-arbitrated from IDLE.
// TESTING
// - Fetch only: if_read=1 addr 0xBFC00000 at cyc0, waitrequest=0, readdata=0x24020001 ->
//   cyc1 read=1 address=0xBFC00000 byteenable=4'hF, if_waitrequest=0, if_readdata=0x24020001; cyc2 IDLE.
// - Tie, ROUND_ROBIN=0: if_read + d_write (0x1000, 0xCAFEF00D, be 4'h3) at cyc0 ->
//   cyc1 write=1 writedata=0xCAFEF00D byteenable=4'h3; cyc2 IDLE; cyc3 fetch read=1.
// - ROUND_ROBIN=1, both held requesting, waitrequest=0 -> grant order D,I,D,I every 2 cycles.
// - Stall: BUS_D read, waitrequest=1 for 3 cycles -> address/read constant, d_waitrequest=1
//   cyc1-3; cyc4 waitrequest=0 -> d_waitrequest=0, d_readdata=readdata; if_waitrequest=1 throughout.
// - TIMEOUT_CYCLES=8, waitrequest stuck 1 -> bus_timeout=1 after 8th stalled cycle, stays 1, still BUS_x.
// - reset_n low mid-stall -> read/write=0, busy=0 same cycle; release with if_read held -> BUS_I next edge.

Source files
------------

// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter: shares one Avalon master port between
// the instruction-fetch (I) and load/store (D) requesters.
module mips_bus_arbiter #(
  parameter bit          ROUND_ROBIN    = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_read,
  input  logic [31:0] if_address,
  output logic        if_waitrequest,
  output logic [31:0] if_readdata,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_address,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic        d_waitrequest,
  output logic [31:0] d_readdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        busy,
  output logic        bus_timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS_I = 2'd1,
    BUS_D = 2'd2
  } state_t;

  state_t      state;
  logic        last_d;
  logic [31:0] stall_cnt;
  logic [31:0] stall_inc;
  logic        d_req;
  logic        d_wins;
  logic        in_bus;

  assign d_req  = d_read | d_write;
  assign d_wins = !ROUND_ROBIN || !last_d;
  assign in_bus = (state == BUS_I) || (state == BUS_D);

  assign stall_inc = (stall_cnt == 32'hFFFF_FFFF)
                   ? stall_cnt : stall_cnt + 32'd1;

  // Arbitration, transfer completion and stall counting
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      last_d    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            (d_req && (!if_read || d_wins)): begin
              state  <= BUS_D;
              last_d <= 1'b1;
            end
            (if_read && !(d_req && d_wins)): begin
              state  <= BUS_I;
              last_d <= 1'b0;
            end
            default: ;
          endcase
        end
        BUS_I, BUS_D: begin
          if (waitrequest) begin
            stall_cnt <= stall_inc;
          end else begin
            state     <= IDLE;
            stall_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky flag: a transfer has stalled for too long
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_timeout <= 1'b0;
    end else if (TIMEOUT_CYCLES != 0 && in_bus && waitrequest
                 && stall_inc >= TIMEOUT_CYCLES) begin
      bus_timeout <= 1'b1;
    end
  end

  // Master port follows the granted requester; quiet when idle
  always_comb begin
    address    = '0;
    read       = 1'b0;
    write      = 1'b0;
    writedata  = '0;
    byteenable = '0;
    unique case (state)
      BUS_I: begin
        address    = if_address;
        read       = 1'b1;
        byteenable = 4'hF;
      end
      BUS_D: begin
        address    = d_address;
        write      = d_write;
        read       = d_read & ~d_write;
        writedata  = d_writedata;
        byteenable = d_byteenable;
      end
      default: ;
    endcase
  end

  // Per-port handshake and read data steering
  always_comb begin
    if_waitrequest = !((state == BUS_I) && !waitrequest);
    d_waitrequest  = !((state == BUS_D) && !waitrequest);
    if_readdata    = (state == BUS_I) ? readdata : '0;
    d_readdata     = (state == BUS_D) ? readdata : '0;
    busy           = (state != IDLE);
  end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// tb_mips_bus_arbiter: directed stimulus with a transfer
// scoreboard per arbiter instance (RR=0/TO=8 and RR=1/TO=0).
module tb_mips_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_read;
  logic [31:0] if_address;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_address;
  logic [31:0] d_writedata;
  logic [3:0]  d_byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  logic        a_if_wait, a_d_wait, a_read, a_write, a_busy, a_to;
  logic [31:0] a_if_rd, a_d_rd, a_addr, a_wd;
  logic [3:0]  a_be;
  logic        b_if_wait, b_d_wait, b_read, b_write, b_busy, b_to;
  logic [31:0] b_if_rd, b_d_rd, b_addr, b_wd;
  logic [3:0]  b_be;

  always #5 clk = ~clk;

  mips_bus_arbiter #(.ROUND_ROBIN(1'b0), .TIMEOUT_CYCLES(8)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .if_read(if_read), .if_address(if_address),
    .if_waitrequest(a_if_wait), .if_readdata(a_if_rd),
    .d_read(d_read), .d_write(d_write), .d_address(d_address),
    .d_writedata(d_writedata), .d_byteenable(d_byteenable),
    .d_waitrequest(a_d_wait), .d_readdata(a_d_rd),
    .address(a_addr), .read(a_read), .write(a_write),
    .writedata(a_wd), .byteenable(a_be),
    .waitrequest(waitrequest), .readdata(readdata),
    .busy(a_busy), .bus_timeout(a_to)
  );

  mips_bus_arbiter #(.ROUND_ROBIN(1'b1), .TIMEOUT_CYCLES(0)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .if_read(if_read), .if_address(if_address),
    .if_waitrequest(b_if_wait), .if_readdata(b_if_rd),
    .d_read(d_read), .d_write(d_write), .d_address(d_address),
    .d_writedata(d_writedata), .d_byteenable(d_byteenable),
    .d_waitrequest(b_d_wait), .d_readdata(b_d_rd),
    .address(b_addr), .read(b_read), .write(b_write),
    .writedata(b_wd), .byteenable(b_be),
    .waitrequest(waitrequest), .readdata(readdata),
    .busy(b_busy), .bus_timeout(b_to)
  );

  typedef struct packed {
    logic [1:0]  waits;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
  } xfer_t;

  xfer_t q0[$];
  xfer_t q1[$];
  xfer_t a_act, b_act;
  int    checks = 0;
  int    errors = 0;
  bit    mon_b  = 1'b0;

  function automatic xfer_t mk(input bit pd, input bit wr,
                               input logic [31:0] ad,
                               input logic [31:0] wd,
                               input logic [3:0] be,
                               input logic [31:0] rd);
    xfer_t x;
    x.waits = pd ? 2'b10 : 2'b01;
    x.wr    = wr;
    x.addr  = ad;
    x.wdata = wd;
    x.be    = be;
    x.rdata = rd;
    return x;
  endfunction

  task automatic cmp_xfer(input string nm, input xfer_t act,
                          input xfer_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got w=%b wr=%b a=%h wd=%h be=%h rd=%h want w=%b wr=%b a=%h wd=%h be=%h rd=%h",
               nm, act.waits, act.wr, act.addr, act.wdata, act.be,
               act.rdata, exp.waits, exp.wr, exp.addr, exp.wdata,
               exp.be, exp.rdata);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act,
                      input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", nm, act, exp);
    end
  endtask

  // Monitor for instance A
  always @(negedge clk) begin
    if ((a_read || a_write) && !waitrequest) begin
      a_act.waits = {a_if_wait, a_d_wait};
      a_act.wr    = a_write;
      a_act.addr  = a_addr;
      a_act.wdata = a_wd;
      a_act.be    = a_be;
      a_act.rdata = a_read ? (a_if_wait ? a_d_rd : a_if_rd) : '0;
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL xfer_a unexpected addr=%h", a_addr);
      end else begin
        cmp_xfer("xfer_a", a_act, q0.pop_front());
      end
    end
  end

  // Monitor for instance B (round-robin test only)
  always @(negedge clk) begin
    if (mon_b && (b_read || b_write) && !waitrequest) begin
      b_act.waits = {b_if_wait, b_d_wait};
      b_act.wr    = b_write;
      b_act.addr  = b_addr;
      b_act.wdata = b_wd;
      b_act.be    = b_be;
      b_act.rdata = b_read ? (b_if_wait ? b_d_rd : b_if_rd) : '0;
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL xfer_b unexpected addr=%h", b_addr);
      end else begin
        cmp_xfer("xfer_b", b_act, q1.pop_front());
      end
    end
  end

  task automatic wait_ack(input bit pd);
    int n;
    n = 0;
    @(negedge clk);
    while ((pd ? a_d_wait : a_if_wait) && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL ack_wait port_d=%0b got none want ack", pd);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got running want finished");
    $fatal(1);
  end

  initial begin
    reset_n      = 1'b0;
    if_read      = 1'b0;
    if_address   = '0;
    d_read       = 1'b0;
    d_write      = 1'b0;
    d_address    = '0;
    d_writedata  = '0;
    d_byteenable = '0;
    waitrequest  = 1'b0;
    readdata     = 32'hFFFF_FFFF;

    #2;
    chk1("rst_read", a_read, 1'b0);
    chk1("rst_write", a_write, 1'b0);
    chk32("rst_addr", a_addr, 32'h0);
    chk32("rst_wdata", a_wd, 32'h0);
    chk32("rst_be", 32'(a_be), 32'h0);
    chk1("rst_if_wait", a_if_wait, 1'b1);
    chk1("rst_d_wait", a_d_wait, 1'b1);
    chk32("rst_if_rd", a_if_rd, 32'h0);
    chk32("rst_d_rd", a_d_rd, 32'h0);
    chk1("rst_busy", a_busy, 1'b0);
    chk1("rst_timeout", a_to, 1'b0);
    if_read = 1'b1;
    @(posedge clk);
    #1;
    chk1("rst_hold_busy", a_busy, 1'b0);
    chk1("rst_hold_read", a_read, 1'b0);
    if_read = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // fetch only
    if_read    = 1'b1;
    if_address = 32'hBFC0_0000;
    readdata   = 32'h2402_0001;
    q0.push_back(mk(0, 0, 32'hBFC0_0000, 0, 4'hF, 32'h2402_0001));
    wait_ack(1'b0);
    if_read = 1'b0;
    @(negedge clk);
    chk1("fetch_idle_busy", a_busy, 1'b0);

    // tie: D write wins, then fetch
    @(posedge clk);
    #1;
    if_read      = 1'b1;
    if_address   = 32'h0000_0100;
    d_write      = 1'b1;
    d_address    = 32'h0000_1000;
    d_writedata  = 32'hCAFE_F00D;
    d_byteenable = 4'h3;
    readdata     = 32'h1111_1111;
    q0.push_back(mk(1, 1, 32'h1000, 32'hCAFE_F00D, 4'h3, 32'h0));
    q0.push_back(mk(0, 0, 32'h0100, 32'h0, 4'hF, 32'h1111_1111));
    wait_ack(1'b1);
    d_write     = 1'b0;
    d_writedata = '0;
    @(negedge clk);
    chk1("tie_turn_busy", a_busy, 1'b0);
    chk1("tie_turn_write", a_write, 1'b0);
    wait_ack(1'b0);
    if_read = 1'b0;

    // round robin vs fixed priority, both held
    do_reset();
    mon_b        = 1'b1;
    if_read      = 1'b1;
    if_address   = 32'h0000_0200;
    d_read       = 1'b1;
    d_address    = 32'h0000_0300;
    d_byteenable = 4'hC;
    readdata     = 32'h5555_AAAA;
    for (int k = 0; k < 4; k++) begin
      q0.push_back(mk(1, 0, 32'h300, 0, 4'hC, 32'h5555_AAAA));
      if (k % 2 == 0)
        q1.push_back(mk(1, 0, 32'h300, 0, 4'hC, 32'h5555_AAAA));
      else
        q1.push_back(mk(0, 0, 32'h200, 0, 4'hF, 32'h5555_AAAA));
    end
    repeat (8) @(posedge clk);
    #1;
    if_read = 1'b0;
    d_read  = 1'b0;
    @(posedge clk);
    #1;
    mon_b = 1'b0;
    chk32("rr_q_empty", q1.size(), 32'd0);

    // stalled D read
    @(posedge clk);
    #1;
    d_read       = 1'b1;
    d_address    = 32'h0000_0400;
    d_byteenable = 4'hF;
    waitrequest  = 1'b1;
    readdata     = 32'hDEAD_BEEF;
    q0.push_back(mk(1, 0, 32'h400, 0, 4'hF, 32'h8BAD_F00D));
    @(negedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk1("stall_d_wait", a_d_wait, 1'b1);
      chk1("stall_read", a_read, 1'b1);
      chk32("stall_addr", a_addr, 32'h400);
      chk1("stall_if_wait", a_if_wait, 1'b1);
      chk32("stall_d_rd", a_d_rd, 32'hDEAD_BEEF);
    end
    @(posedge clk);
    #1;
    waitrequest = 1'b0;
    readdata    = 32'h8BAD_F00D;
    @(negedge clk);
    chk1("stall_done_if_wait", a_if_wait, 1'b1);
    @(posedge clk);
    #1;
    d_read = 1'b0;
    @(posedge clk);
    #1;

    // stuck bus -> sticky timeout
    if_read     = 1'b1;
    if_address  = 32'h0000_0500;
    waitrequest = 1'b1;
    @(negedge clk);
    repeat (8) @(negedge clk);
    chk1("to_before", a_to, 1'b0);
    @(negedge clk);
    chk1("to_set", a_to, 1'b1);
    chk1("to_busy", a_busy, 1'b1);
    chk1("to_read", a_read, 1'b1);
    chk1("to_disabled_b", b_to, 1'b0);
    repeat (3) @(negedge clk);
    chk1("to_sticky", a_to, 1'b1);
    chk1("to_if_wait", a_if_wait, 1'b1);

    // reset mid-stall, fetch still requested
    #1 reset_n = 1'b0;
    #1;
    chk1("mid_rst_read", a_read, 1'b0);
    chk1("mid_rst_busy", a_busy, 1'b0);
    chk1("mid_rst_to", a_to, 1'b0);
    chk32("mid_rst_addr", a_addr, 32'h0);
    chk1("mid_rst_if_wait", a_if_wait, 1'b1);
    @(posedge clk);
    #1;
    waitrequest = 1'b0;
    readdata    = 32'h0BAD_C0DE;
    q0.push_back(mk(0, 0, 32'h500, 0, 4'hF, 32'h0BAD_C0DE));
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk1("post_rst_busy", a_busy, 1'b1);
    wait_ack(1'b0);
    if_read = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk32("sb_empty", q0.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
